// File: rtl/ulpi_init_seq.sv
`timescale 1ns/1ps
// ULPI PHY bring-up sequencer: waits for a quiet DIR after reset, then writes a
// fixed three-entry register table through the register-write stage, with retries.
module ulpi_init_seq #(
    parameter logic [15:0] STARTUP_CYCLES = 16'd1024,
    parameter logic [7:0]  GAP_CYCLES     = 8'd4,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64,
    parameter logic [1:0]  MAX_RETRY      = 2'd2
) (
    input  logic       clk_ULPI,
    input  logic       rst,
    input  logic       start,
    input  logic       DIR,
    input  logic       wr_busy,
    output logic       PrW,
    output logic [5:0] ADDR,
    output logic [7:0] REG_VAL,
    output logic       done,
    output logic       error,
    output logic [1:0] entry_idx,
    output logic [2:0] state_dbg
);

    // Handshake: PrW is a single-cycle request carrying ADDR/REG_VAL. The writer
    // accepts by raising wr_busy and completes by dropping it; ADDR/REG_VAL stay
    // valid from GAP until the attempt resolves.
    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_GAP       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t      state;
    logic [15:0] su_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  to_cnt;
    logic        ack_cnt;
    logic [1:0]  retry;

    logic su_last;
    logic gap_full;
    logic to_last;
    logic attempt_ok;
    logic attempt_fail;

    // Terminal tests computed one bit wider so a zero-length parameter cannot wrap.
    assign su_last  = ({1'b0, su_cnt} + 17'd1) >= {1'b0, STARTUP_CYCLES};
    assign gap_full = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, GAP_CYCLES};
    assign to_last  = ({1'b0, to_cnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};

    assign attempt_ok   = (state == ST_WAIT_DONE) && !wr_busy;
    assign attempt_fail = ((state == ST_WAIT_ACK) && !wr_busy && ack_cnt) ||
                          ((state == ST_WAIT_DONE) && wr_busy && to_last);

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            state     <= ST_STARTUP;
            su_cnt    <= 16'd0;
            gap_cnt   <= 8'd0;
            to_cnt    <= 8'd0;
            ack_cnt   <= 1'b0;
            retry     <= 2'd0;
            entry_idx <= 2'd0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    if (DIR) begin
                        su_cnt <= 16'd0;
                    end else if (su_last) begin
                        su_cnt  <= 16'd0;
                        gap_cnt <= 8'd0;
                        state   <= ST_GAP;
                    end else begin
                        su_cnt <= su_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_full) begin
                        if (!DIR && !wr_busy) begin
                            gap_cnt <= 8'd0;
                            state   <= ST_ISSUE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    ack_cnt <= 1'b0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK, ST_WAIT_DONE: begin
                    if (attempt_ok) begin
                        retry   <= 2'd0;
                        gap_cnt <= 8'd0;
                        if (entry_idx == 2'd2) begin
                            state <= ST_DONE;
                        end else begin
                            entry_idx <= entry_idx + 2'd1;
                            state     <= ST_GAP;
                        end
                    end else if (attempt_fail) begin
                        gap_cnt <= 8'd0;
                        if (retry < MAX_RETRY) begin
                            retry <= retry + 2'd1;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end else if (state == ST_WAIT_ACK) begin
                        if (wr_busy) begin
                            to_cnt <= 8'd0;
                            state  <= ST_WAIT_DONE;
                        end else begin
                            ack_cnt <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    // Re-run skips STARTUP: the PHY link is already known to be up.
                    if (start) begin
                        entry_idx <= 2'd0;
                        retry     <= 2'd0;
                        gap_cnt   <= 8'd0;
                        state     <= ST_GAP;
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

    assign PrW       = (state == ST_ISSUE);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign state_dbg = state;

    always_comb begin
        ADDR    = 6'h0A;
        REG_VAL = 8'h00;
        case (entry_idx)
            2'd1: begin ADDR = 6'h07; REG_VAL = 8'h00; end
            2'd2: begin ADDR = 6'h04; REG_VAL = 8'h49; end
            default: begin ADDR = 6'h0A; REG_VAL = 8'h00; end
        endcase
    end

endmodule

// File: tb/tb_ulpi_init_seq.sv
`timescale 1ns/1ps
// Bench for ulpi_init_seq: a writer model answers PrW per a per-attempt plan and a
// reference model predicts the write list, pulse spacing and final outcome.
module tb_ulpi_init_seq;

    localparam int STARTUP = 1024;
    localparam int GAP     = 4;
    localparam int TMO     = 64;
    localparam int MAXR    = 2;

    logic       clk_ULPI;
    logic       rst;
    logic       start;
    logic       DIR;
    logic       wr_busy;
    logic       PrW;
    logic [5:0] ADDR;
    logic [7:0] REG_VAL;
    logic       done;
    logic       error;
    logic [1:0] entry_idx;
    logic [2:0] state_dbg;

    int vectors;
    int miscompares;
    int cyc;
    int pulse_err;
    int both_err;
    bit prw_prev;
    int busy_left;

    int          wr_plan[$];
    int          prw_cyc[$];
    logic [13:0] prw_wr[$];
    logic [13:0] exp_q[$];
    int          exp_iv[$];

    ulpi_init_seq dut (
        .clk_ULPI (clk_ULPI),
        .rst      (rst),
        .start    (start),
        .DIR      (DIR),
        .wr_busy  (wr_busy),
        .PrW      (PrW),
        .ADDR     (ADDR),
        .REG_VAL  (REG_VAL),
        .done     (done),
        .error    (error),
        .entry_idx(entry_idx),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial begin
        clk_ULPI = 1'b0;
        forever #8 clk_ULPI = ~clk_ULPI;
    end

    // Writer model: busy for L cycles starting one cycle after each PrW; L=0 never acks.
    initial begin
        wr_busy   = 1'b0;
        busy_left = 0;
        forever begin
            @(posedge clk_ULPI);
            #1;
            if (busy_left > 0) begin
                wr_busy   = 1'b1;
                busy_left = busy_left - 1;
            end else begin
                wr_busy = 1'b0;
            end
            if (PrW === 1'b1) busy_left = (wr_plan.size() > 0) ? wr_plan.pop_front() : 4;
        end
    end

    // Monitor: cycle count, PrW log, pulse-width and done/error exclusivity tracking.
    initial begin
        cyc = 0; pulse_err = 0; both_err = 0; prw_prev = 1'b0;
        forever begin
            @(posedge clk_ULPI);
            #1;
            cyc = cyc + 1;
            if (PrW === 1'b1) begin
                prw_cyc.push_back(cyc);
                prw_wr.push_back({ADDR, REG_VAL});
                if (prw_prev) pulse_err = pulse_err + 1;
            end
            prw_prev = (PrW === 1'b1);
            if (done === 1'b1 && error === 1'b1) both_err = both_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] tbl(input int e);
        case (e)
            0:       return {6'h0A, 8'h00};
            1:       return {6'h07, 8'h00};
            default: return {6'h04, 8'h49};
        endcase
    endfunction

    // Reference model: walks entries/attempts using the plan and derives the spacing
    // between consecutive PrW pulses from the cycle rules of each attempt outcome.
    task automatic model(input int plan_in[$], output logic e_done, output logic e_err,
                         output logic [1:0] e_idx);
        int plan[$];
        int e, r, len, iv;
        bit fin, ok;
        plan = plan_in;
        exp_q.delete();
        exp_iv.delete();
        e = 0; r = 0; fin = 0; e_done = 0; e_err = 0;
        while (!fin) begin
            len = (plan.size() > 0) ? plan.pop_front() : 4;
            exp_q.push_back(tbl(e));
            ok = (len >= 1) && (len <= TMO);
            if (ok)            iv = len + 2 + GAP;
            else if (len == 0) iv = 3 + GAP;
            else               iv = ((2 + TMO + GAP) > (len + 2)) ? (2 + TMO + GAP) : (len + 2);
            if (ok) begin
                r = 0;
                if (e == 2) begin fin = 1; e_done = 1; end
                else e = e + 1;
            end else if (r < MAXR) begin
                r = r + 1;
            end else begin
                fin = 1; e_err = 1;
            end
            if (!fin) exp_iv.push_back(iv);
        end
        e_idx = 2'(e);
    endtask

    task automatic clear_log();
        prw_cyc.delete();
        prw_wr.delete();
    endtask

    task automatic run_check(input string tag, input int plan[$], input int t0, input bit poke);
        logic ed, ee;
        logic [1:0] ei;
        int n;
        bit poked;
        model(plan, ed, ee, ei);
        poked = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_ULPI);
            if (poke && !poked && prw_wr.size() == 1) begin
                start = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1 || error === 1'b1) break;
        end
        start = 1'b0;
        chk({tag, "_end_reached"}, 32'(done | error), 32'd1);
        repeat (4) @(negedge clk_ULPI);
        chk({tag, "_nwrites"}, prw_wr.size(), exp_q.size());
        n = (prw_wr.size() < exp_q.size()) ? prw_wr.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wr%0d", tag, i), prw_wr[i], exp_q[i]);
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), prw_cyc[i] - prw_cyc[i-1], exp_iv[i-1]);
        end
        if (prw_cyc.size() > 0) chk({tag, "_first_prw_cyc"}, prw_cyc[0], t0);
        chk({tag, "_done"}, done, ed);
        chk({tag, "_error"}, error, ee);
        chk({tag, "_entry_idx"}, entry_idx, ei);
        chk({tag, "_prw_width"}, pulse_err, 0);
        chk({tag, "_done_err_excl"}, both_err, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_prw"}, PrW, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_idx"}, entry_idx, 2'd0);
        chk({tag, "_addr"}, ADDR, 6'h0A);
        chk({tag, "_val"}, REG_VAL, 8'h00);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk_ULPI);
        start = 1'b1;
        s = cyc;
        @(negedge clk_ULPI);
        start = 1'b0;
    endtask

    initial begin
        int plan[$];
        int rel, s, p;
        vectors = 0; miscompares = 0;
        rst = 1'b0; start = 1'b0; DIR = 1'b0;
        repeat (3) @(negedge clk_ULPI);
        chk_reset_vals("por");

        // Nominal from reset with random busy lengths; start mid-sequence is ignored.
        plan = '{};
        for (int i = 0; i < 3; i++) plan.push_back($urandom_range(8, 1));
        wr_plan = plan;
        clear_log();
        @(negedge clk_ULPI);
        rst = 1'b1;
        rel = cyc;
        run_check("nominal", plan, rel + STARTUP + GAP, 1'b1);

        // Restart from DONE: straight to GAP, no STARTUP.
        plan = '{};
        for (int i = 0; i < 3; i++) plan.push_back($urandom_range(10, 1));
        wr_plan = plan; clear_log();
        pulse_start(s);
        run_check("restart", plan, s + 1 + GAP, 1'b0);

        // No ack on first attempt of entry0, then acked.
        plan = '{0, $urandom_range(6, 1), 4, 4};
        wr_plan = plan; clear_log();
        pulse_start(s);
        run_check("noack1", plan, s + 1 + GAP, 1'b0);

        // No ack on every attempt: ERROR on entry0.
        plan = '{0, 0, 0};
        wr_plan = plan; clear_log();
        pulse_start(s);
        run_check("noack3", plan, s + 1 + GAP, 1'b0);

        // Start from ERROR; entry1 busy far past timeout on every attempt.
        plan = '{$urandom_range(6, 1), $urandom_range(90, 70), $urandom_range(90, 70), $urandom_range(90, 70)};
        wr_plan = plan; clear_log();
        pulse_start(s);
        run_check("timeout", plan, s + 1 + GAP, 1'b0);

        // Reset, then a DIR pulse during STARTUP restarts the quiet-period count.
        @(negedge clk_ULPI);
        rst = 1'b0;
        #1;
        chk_reset_vals("rst2");
        plan = '{};
        for (int i = 0; i < 3; i++) plan.push_back($urandom_range(8, 1));
        @(negedge clk_ULPI);
        wr_plan = plan; clear_log();
        rst = 1'b1;
        rel = cyc;
        p = $urandom_range(1000, 1);
        while (cyc < rel + p) @(negedge clk_ULPI);
        DIR = 1'b1;
        @(negedge clk_ULPI);
        DIR = 1'b0;
        run_check("dirpulse", plan, rel + p + 1 + STARTUP + GAP, 1'b0);

        // Reset during WAIT_DONE of entry2, then a full sequence from STARTUP.
        plan = '{4, 4, 4};
        wr_plan = plan; clear_log();
        pulse_start(s);
        for (int i = 0; i < 200; i++) begin
            if (prw_wr.size() >= 3) break;
            @(negedge clk_ULPI);
        end
        chk("midwr_prw3", prw_wr.size(), 3);
        repeat (2) @(negedge clk_ULPI);
        chk("midwr_idx_before", entry_idx, 2'd2);
        rst = 1'b0;
        #1;
        chk_reset_vals("midwr_rst");
        @(negedge clk_ULPI);
        plan = '{};
        for (int i = 0; i < 3; i++) plan.push_back($urandom_range(8, 1));
        wr_plan = plan; clear_log();
        rst = 1'b1;
        rel = cyc;
        run_check("after_rst", plan, rel + STARTUP + GAP, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
